// File: rtl/phy_init_seq_multi_pkg.sv
// phy_init_seq_multi_pkg: shared state encoding and helpers for the staggered PHY initialiser
package phy_init_seq_multi_pkg;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD, SETTLE} state_t;

    function automatic int max3(input int a, input int b, input int c);
        max3 = (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

    function automatic logic [2:0] first_set(input logic [7:0] v);
        first_set = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) first_set = 3'(i);
    endfunction

endpackage

// File: rtl/phy_seq_timer.sv
// phy_seq_timer: loadable down-counter that parks at zero
module phy_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk_50,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // load wins over counting; no wrap below zero
    always_ff @(posedge clk_50) begin
        if (reset) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phy_init_seq_multi.sv
// phy_init_seq_multi: sequences NUM_PHY PHYs through reset, strap hold and settle one at a time
module phy_init_seq_multi
    import phy_init_seq_multi_pkg::*;
#(
    parameter int NUM_PHY       = 2,
    parameter int STRAP_W       = 14,
    parameter int RST_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 50,
    parameter int SETTLE_CYCLES = 250000
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic [NUM_PHY*STRAP_W-1:0] strap_cfg,
    input  logic [NUM_PHY-1:0]         reinit_req,
    output logic [NUM_PHY*STRAP_W-1:0] strap_out,
    output logic [NUM_PHY-1:0]         strap_oe,
    output logic [NUM_PHY-1:0]         phy_hw_rst_n,
    output logic [NUM_PHY-1:0]         phy_ready,
    output logic                       busy
);

    localparam int CW = $clog2(max3(RST_CYCLES, HOLD_CYCLES, SETTLE_CYCLES) + 1);
    localparam int KW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [NUM_PHY-1:0]         pending_q, pend_d, accept;
    logic [NUM_PHY*STRAP_W-1:0] strap_q;
    logic [NUM_PHY-1:0]         oe_q, rst_n_q, ready_q;
    logic                       busy_q, restart, tload, zero;
    logic [CW-1:0]              tval, tcnt;

    phy_seq_timer #(.W(CW)) u_timer (
        .clk_50     (clk_50),
        .reset      (reset),
        .load_i     (tload),
        .load_val_i (tval),
        .cnt_o      (tcnt),
        .zero_o     (zero)
    );

    // next state, pending mask and timer reloads; a restart of the active channel
    // loads one extra cycle so it matches the IDLE-select cycle of a normal re-init
    always_comb begin
        restart = (state_q != IDLE) && reinit_req[k_q];
        accept  = reinit_req & ready_q;
        state_d = state_q;
        k_d     = k_q;
        pend_d  = pending_q | accept;
        tload   = restart;
        tval    = CW'(RST_CYCLES);
        case (state_q)
            IDLE: if (|pending_q) begin
                state_d = ASSERT;
                k_d     = KW'(first_set(8'(pending_q)));
                tload   = 1'b1;
                tval    = CW'(RST_CYCLES - 1);
            end
            ASSERT: if (zero) begin
                state_d = HOLD;
                tload   = 1'b1;
                tval    = CW'(HOLD_CYCLES - 1);
            end
            HOLD: if (zero) begin
                state_d = SETTLE;
                tload   = 1'b1;
                tval    = CW'(SETTLE_CYCLES - 1);
            end
            default: if (zero) begin
                state_d     = IDLE;
                pend_d[k_q] = 1'b0;
            end
        endcase
        if (restart) begin
            state_d     = ASSERT;
            tload       = 1'b1;
            tval        = CW'(RST_CYCLES);
            pend_d[k_q] = 1'b1;
        end
    end

    // sequencer state and per-channel registered pin controls
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            pending_q <= '1;
            strap_q   <= strap_cfg;
            oe_q      <= '1;
            rst_n_q   <= '0;
            ready_q   <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pending_q <= pend_d;
            busy_q    <= (state_d != IDLE) || (|pend_d);
            for (int j = 0; j < NUM_PHY; j++)
                if (accept[j]) begin
                    ready_q[j]                   <= 1'b0;
                    rst_n_q[j]                   <= 1'b0;
                    oe_q[j]                      <= 1'b1;
                    strap_q[j*STRAP_W +: STRAP_W] <= strap_cfg[j*STRAP_W +: STRAP_W];
                end
            if (restart) begin
                rst_n_q[k_q]                   <= 1'b0;
                oe_q[k_q]                      <= 1'b1;
                strap_q[k_q*STRAP_W +: STRAP_W] <= strap_cfg[k_q*STRAP_W +: STRAP_W];
            end else if (zero && state_q == ASSERT) rst_n_q[k_q] <= 1'b1;
            else if (zero && state_q == HOLD) oe_q[k_q] <= 1'b0;
            else if (zero && state_q == SETTLE) ready_q[k_q] <= 1'b1;
        end
    end

    assign strap_out    = strap_q;
    assign strap_oe     = oe_q;
    assign phy_hw_rst_n = rst_n_q;
    assign phy_ready    = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_phy_init_seq_multi.sv
// tb_phy_init_seq_multi: directed scenarios plus random traffic against a timeline model
module tb_phy_init_seq_multi;

    localparam int NP = 2;
    localparam int SW = 14;
    localparam int R  = 4;
    localparam int H  = 2;
    localparam int S  = 3;
    localparam int T  = R + H + S;

    logic               clk_50 = 1'b0;
    logic               reset;
    logic [NP*SW-1:0]   strap_cfg;
    logic [NP-1:0]      reinit_req;
    logic [NP*SW-1:0]   strap_out;
    logic [NP-1:0]      strap_oe, phy_hw_rst_n, phy_ready;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;
    int act   = -1;
    int s     = 0;
    logic [NP-1:0]    m_pend  = '1;
    logic [NP-1:0]    m_ready = '0;
    logic [NP*SW-1:0] m_strap = '0;

    phy_init_seq_multi #(
        .NUM_PHY(NP), .STRAP_W(SW), .RST_CYCLES(R), .HOLD_CYCLES(H), .SETTLE_CYCLES(S)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .strap_cfg    (strap_cfg),
        .reinit_req   (reinit_req),
        .strap_out    (strap_out),
        .strap_oe     (strap_oe),
        .phy_hw_rst_n (phy_hw_rst_n),
        .phy_ready    (phy_ready),
        .busy         (busy)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // channel timeline: the active channel's pins follow from cycles elapsed since it was
    // selected; every other channel is either fully released (ready) or held in reset
    task automatic model_step();
        logic [NP-1:0] old_ready, old_pend;
        n++;
        if (reset) begin
            m_pend  = '1;
            m_ready = '0;
            m_strap = strap_cfg;
            act     = -1;
        end else begin
            old_ready = m_ready;
            old_pend  = m_pend;
            if (act >= 0) begin
                if (reinit_req[act]) begin
                    s = n + 1;
                    m_strap[act*SW +: SW] = strap_cfg[act*SW +: SW];
                end else if (n - s == T) begin
                    m_ready[act] = 1'b1;
                    m_pend[act]  = 1'b0;
                    act          = -1;
                end
            end else if (old_pend != '0) begin
                for (int j = NP - 1; j >= 0; j--)
                    if (old_pend[j]) act = j;
                s = n;
            end
            for (int j = 0; j < NP; j++)
                if (reinit_req[j] && old_ready[j]) begin
                    m_ready[j] = 1'b0;
                    m_pend[j]  = 1'b1;
                    m_strap[j*SW +: SW] = strap_cfg[j*SW +: SW];
                end
        end
    endtask

    task automatic tick();
        logic [NP-1:0] e_rstn, e_oe;
        @(posedge clk_50);
        model_step();
        @(negedge clk_50);
        for (int j = 0; j < NP; j++) begin
            e_rstn[j] = (j == act) ? ((n - s) >= R) : m_ready[j];
            e_oe[j]   = (j == act) ? ((n - s) < R + H) : !m_ready[j];
        end
        chk("strap_out", 64'(strap_out), 64'(m_strap));
        chk("strap_oe", 64'(strap_oe), 64'(e_oe));
        chk("hw_rst_n", 64'(phy_hw_rst_n), 64'(e_rstn));
        chk("ready", 64'(phy_ready), 64'(m_ready));
        chk("busy", 64'(busy), 64'((act >= 0) || (m_pend != '0)));
    endtask

    initial begin
        reset      = 1'b1;
        reinit_req = '0;
        strap_cfg  = {14'h1FFF, 14'h0A55};
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rstn", 64'(phy_hw_rst_n), 64'd0);

        reset = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 2) strap_cfg = 28'($urandom);
            if (i == 4) chk("t1_rstn0_low", 64'(phy_hw_rst_n[0]), 64'd0);
            if (i == 5) chk("t1_rstn0_high", 64'(phy_hw_rst_n[0]), 64'd1);
            if (i == 6) chk("t2_oe0_hold", 64'(strap_oe[0]), 64'd1);
            if (i == 7) chk("t2_oe0_settle", 64'(strap_oe[0]), 64'd0);
            if (i == 9) chk("t1_ready0_early", 64'(phy_ready[0]), 64'd0);
            if (i == 10) chk("t1_ready0", 64'(phy_ready[0]), 64'd1);
            if (i == 19) chk("t1_busy_pre", 64'(busy), 64'd1);
            if (i == 20) chk("t1_ready1", 64'(phy_ready[1]), 64'd1);
            if (i == 20) chk("t1_busy_fall", 64'(busy), 64'd0);
            if (i == 20) chk("t2_strap_kept", 64'(strap_out), 64'h0000_0000_07FF_CA55);
        end

        strap_cfg  = 28'($urandom);
        reinit_req = 2'b01;
        tick();
        reinit_req = '0;
        chk("t3_ready0_drop", 64'(phy_ready[0]), 64'd0);
        chk("t3_rstn0_drop", 64'(phy_hw_rst_n[0]), 64'd0);
        chk("t3_ready1_kept", 64'(phy_ready[1]), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9) chk("t3_ready0_early", 64'(phy_ready[0]), 64'd0);
            if (i == 10) chk("t3_ready0_back", 64'(phy_ready[0]), 64'd1);
        end

        reinit_req = 2'b11;
        tick();
        reinit_req = '0;
        chk("t4_both_drop", 64'(phy_ready), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) chk("t4_ch0_first", 64'(phy_ready), 64'b01);
            if (i == 20) chk("t4_ch1_later", 64'(phy_ready), 64'b11);
        end

        reinit_req = 2'b01;
        tick();
        reinit_req = '0;
        repeat (5) tick();
        chk("t5_in_hold", 64'(phy_hw_rst_n[0]), 64'd1);
        strap_cfg  = 28'($urandom);
        reinit_req = 2'b01;
        tick();
        reinit_req = '0;
        chk("t5_restart_rstn", 64'(phy_hw_rst_n[0]), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9) chk("t5_ready0_early", 64'(phy_ready[0]), 64'd0);
            if (i == 10) chk("t5_ready0", 64'(phy_ready[0]), 64'd1);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (17) tick();
        chk("t6_ch1_settle", 64'(strap_oe[1]), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_ready_rst", 64'(phy_ready), 64'd0);
        chk("t6_oe_rst", 64'(strap_oe), 64'b11);
        chk("t6_busy_rst", 64'(busy), 64'd1);
        repeat (22) tick();
        chk("t6_replay", 64'(phy_ready), 64'b11);

        for (int i = 0; i < 500; i++) begin
            strap_cfg  = 28'($urandom);
            reinit_req = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset      = 1'b0;
        reinit_req = '0;
        repeat (25) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
